// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver.
// Glyph table is active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODES_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    // Entry n is the glyph for nibble n; b and d are lower case.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
    };

    function automatic logic [6:0] glyph(input logic [3:0] n);
        return GLYPHS[n];
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low segment decoder.
// Ports: nibble (4b in), seg (7b {g..a} active-low out).
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = glyph(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with shadowed frame loads.
// Ports: clk, reset (sync high), digits_in/dp_in/blank_lz with
// load_valid/load_ready handshake, an/seg/dp (active-low), frame_done.
module seven_seg_scan_driver
    import seg_pkg::*;
#(
    parameter int PRESCALE     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int            PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PS_BLNK = PW'(BLANK_CYCLES);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    slot_q, slot_d;
    logic [15:0]   sh_word_q, sh_word_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic          sh_blz_q, sh_blz_d;
    logic          pending_q, pending_d;
    logic [15:0]   act_word_q, act_word_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic          act_blz_q, act_blz_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;

    logic          wrap, boundary, accept, guard, blank;
    logic [3:0]    nib;
    logic [3:0]    lz;
    logic [6:0]    dec_seg;

    hex_to_seg u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    always_comb begin
        wrap     = (presc_q == PS_LAST);
        boundary = wrap && (slot_q == 2'd3);
        accept   = load_valid && !pending_q;

        presc_d = wrap ? '0 : presc_q + 1'b1;
        slot_d  = wrap ? slot_q + 2'd1 : slot_q;

        sh_word_d  = sh_word_q;
        sh_dp_d    = sh_dp_q;
        sh_blz_d   = sh_blz_q;
        pending_d  = pending_q;
        act_word_d = act_word_q;
        act_dp_d   = act_dp_q;
        act_blz_d  = act_blz_q;

        // A word accepted on the boundary cycle is not yet pending,
        // so it waits a full frame; the shown word never tears.
        if (boundary && pending_q) begin
            act_word_d = sh_word_q;
            act_dp_d   = sh_dp_q;
            act_blz_d  = sh_blz_q;
            pending_d  = 1'b0;
        end
        if (accept) begin
            sh_word_d = digits_in;
            sh_dp_d   = dp_in;
            sh_blz_d  = blank_lz;
            pending_d = 1'b1;
        end

        nib = act_word_q[{slot_q, 2'b00} +: 4];

        // lz[k]: nibbles k..3 are all zero; digit 0 never blanks.
        lz[3] = (act_word_q[15:12] == 4'h0);
        lz[2] = lz[3] && (act_word_q[11:8] == 4'h0);
        lz[1] = lz[2] && (act_word_q[7:4] == 4'h0);
        lz[0] = 1'b0;
        blank = act_blz_q && lz[slot_q];

        guard = (presc_q < PS_BLNK);
        an_d  = guard ? ANODES_OFF : ~(4'b0001 << slot_q);
        seg_d = blank ? SEG_OFF : dec_seg;
        dp_d  = ~act_dp_q[slot_q];
        fd_d  = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            slot_q     <= 2'd0;
            sh_word_q  <= 16'h0;
            sh_dp_q    <= 4'h0;
            sh_blz_q   <= 1'b0;
            pending_q  <= 1'b0;
            act_word_q <= 16'h0;
            act_dp_q   <= 4'h0;
            act_blz_q  <= 1'b0;
            an_q       <= ANODES_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            slot_q     <= slot_d;
            sh_word_q  <= sh_word_d;
            sh_dp_q    <= sh_dp_d;
            sh_blz_q   <= sh_blz_d;
            pending_q  <= pending_d;
            act_word_q <= act_word_d;
            act_dp_q   <= act_dp_d;
            act_blz_q  <= act_blz_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign load_ready = !pending_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver.
// PRESCALE=8, BLANK_CYCLES=2: one frame is 32 clocks.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int vecs = 0;
    int errs = 0;
    int rel  = 0;

    seven_seg_scan_driver #(
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rel++;
    endtask

    task automatic tick_rel(input int target);
        while (rel < target) tick();
    endtask

    // rel counts negedges since the last frame_done sample; the
    // registered view of (slot j, prescaler p) is at rel 8j+p+1.
    task automatic at_slot(input int j, input int p);
        tick_rel(8 * j + p + 1);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        tick();
        while (frame_done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        chk("frame_done_seen", {31'b0, frame_done}, 32'd1);
        rel = 0;
    endtask

    task automatic load(input logic [15:0] w, input logic [3:0] d,
                        input logic b);
        digits_in  = w;
        dp_in      = d;
        blank_lz   = b;
        load_valid = 1'b1;
        tick();
        chk("ready_drop", {31'b0, load_ready}, 32'd0);
        load_valid = 1'b0;
    endtask

    task automatic see(input string tag, input int j, input int p,
                       input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp);
        at_slot(j, p);
        chk({tag, "_an"}, {28'b0, an}, {28'b0, e_an});
        chk({tag, "_seg"}, {25'b0, seg}, {25'b0, e_seg});
        chk({tag, "_dp"}, {31'b0, dp}, {31'b0, e_dp});
    endtask

    initial begin
        reset      = 1'b1;
        digits_in  = 16'h0;
        dp_in      = 4'h0;
        blank_lz   = 1'b0;
        load_valid = 1'b0;

        // 1: reset and first-slot timing
        repeat (3) @(negedge clk);
        chk("rst_an", {28'b0, an}, 32'hF);
        chk("rst_seg", {25'b0, seg}, 32'h7F);
        chk("rst_dp", {31'b0, dp}, 32'd1);
        chk("rst_rdy", {31'b0, load_ready}, 32'd1);
        chk("rst_fd", {31'b0, frame_done}, 32'd0);
        reset = 1'b0;
        rel = 0;
        tick();
        chk("guard_c1", {28'b0, an}, 32'hF);
        tick();
        chk("guard_c2", {28'b0, an}, 32'hF);
        tick();
        chk("an0_c3", {28'b0, an}, 32'hE);
        chk("seg0_c3", {25'b0, seg}, 32'h40);
        tick_rel(8);
        chk("an0_c8", {28'b0, an}, 32'hE);
        tick();
        chk("guard_s1", {28'b0, an}, 32'hF);

        // 2: 1234 with dp on digit 2
        load(16'h1234, 4'b0100, 1'b0);
        wait_frame();
        chk("rdy_back", {31'b0, load_ready}, 32'd1);
        tick();
        chk("fd_pulse", {31'b0, frame_done}, 32'd0);
        see("t2s0", 0, 4, 4'hE, 7'h19, 1'b1);
        at_slot(1, 0);
        chk("t2g1_an", {28'b0, an}, 32'hF);
        chk("t2g1_seg", {25'b0, seg}, 32'h30);
        see("t2s2", 2, 4, 4'hB, 7'h24, 1'b0);
        see("t2s3", 3, 4, 4'h7, 7'h79, 1'b1);

        // 3: leading-zero blanking
        load(16'h0050, 4'b0000, 1'b1);
        wait_frame();
        see("t3s0", 0, 4, 4'hE, 7'h40, 1'b1);
        see("t3s1", 1, 4, 4'hD, 7'h12, 1'b1);
        see("t3s2", 2, 4, 4'hB, 7'h7F, 1'b1);
        see("t3s3", 3, 4, 4'h7, 7'h7F, 1'b1);
        load(16'h0000, 4'b1000, 1'b1);
        wait_frame();
        see("t3z0", 0, 4, 4'hE, 7'h40, 1'b1);
        see("t3z1", 1, 4, 4'hD, 7'h7F, 1'b1);
        see("t3z3", 3, 4, 4'h7, 7'h7F, 1'b0);

        // 4: accept on the boundary cycle
        tick_rel(31);
        digits_in  = 16'hABCD;
        dp_in      = 4'h0;
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        tick();
        chk("t4_fd", {31'b0, frame_done}, 32'd1);
        chk("t4_rdy0", {31'b0, load_ready}, 32'd0);
        load_valid = 1'b0;
        rel = 0;
        see("t4old0", 0, 4, 4'hE, 7'h40, 1'b1);
        see("t4old3", 3, 4, 4'h7, 7'h7F, 1'b0);
        chk("t4_rdy_mid", {31'b0, load_ready}, 32'd0);
        wait_frame();
        chk("t4_rdy1", {31'b0, load_ready}, 32'd1);
        see("t4new0", 0, 4, 4'hE, 7'h21, 1'b1);
        see("t4new3", 3, 4, 4'h7, 7'h08, 1'b1);

        // 5: valid held while not ready is ignored
        wait_frame();
        load(16'h5678, 4'b0000, 1'b0);
        digits_in  = 16'h9999;
        load_valid = 1'b1;
        repeat (5) tick();
        load_valid = 1'b0;
        wait_frame();
        see("t5s0", 0, 4, 4'hE, 7'h00, 1'b1);
        see("t5s1", 1, 4, 4'hD, 7'h78, 1'b1);
        see("t5s3", 3, 4, 4'h7, 7'h12, 1'b1);

        // 6: reset mid-slot 2 with a load pending
        wait_frame();
        tick_rel(9);
        load(16'hEEEE, 4'hF, 1'b0);
        at_slot(2, 4);
        reset = 1'b1;
        tick();
        chk("t6_an", {28'b0, an}, 32'hF);
        chk("t6_seg", {25'b0, seg}, 32'h7F);
        chk("t6_dp", {31'b0, dp}, 32'd1);
        chk("t6_rdy", {31'b0, load_ready}, 32'd1);
        chk("t6_fd", {31'b0, frame_done}, 32'd0);
        reset = 1'b0;
        wait_frame();
        see("t6s2", 2, 4, 4'hB, 7'h40, 1'b1);
        see("t6s3", 3, 4, 4'h7, 7'h40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
